// File: rtl/ultrasonic_echo_emulator.sv
// Ultrasonic ranging sensor responder (HC-SR04 style trig/echo interface).
// A trigger pulse of sufficient length is answered, after a fixed burst time,
// by an echo pulse whose width encodes the supplied distance.
module ultrasonic_echo_emulator #(
    parameter int CLK_FREQ          = 50000000, // informational only; timing is in cycles
    parameter int CYCLES_PER_CM     = 2915,
    parameter int MIN_TRIG_CYCLES   = 500,
    parameter int ECHO_DELAY_CYCLES = 25000,
    parameter int MAX_DIST_CM       = 400,
    parameter int TIMEOUT_CYCLES    = 1900000,
    parameter int HOLDOFF_CYCLES    = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trig,
    input  logic [8:0] dist_cm,
    input  logic       obj_present,
    output logic       echo,
    output logic       busy,
    output logic       trig_err
);

    localparam logic [21:0] CPC_C     = 22'(CYCLES_PER_CM);
    localparam logic [21:0] MIN_C     = 22'(MIN_TRIG_CYCLES);
    localparam logic [21:0] DELAY_C   = 22'(ECHO_DELAY_CYCLES);
    localparam logic [21:0] TIMEOUT_C = 22'(TIMEOUT_CYCLES);
    localparam logic [21:0] HOLD_C    = 22'(HOLDOFF_CYCLES);
    localparam logic [8:0]  MAXD_C    = 9'(MAX_DIST_CM);

    typedef enum logic [2:0] {
        IDLE, TRIG_MEAS, BURST, ECHO, HOLDOFF
    } state_t;

    state_t      state_q, state_d;
    logic [21:0] cnt_q, cnt_d;
    logic [21:0] echo_len_q, echo_len_d;
    logic        echo_q, echo_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic        sync1_q, sync2_q, prev_q;

    logic        trig_rise, trig_fall;
    logic [21:0] cnt_inc;
    logic [8:0]  dist_clamped;
    logic [21:0] len_calc;

    // Two-stage synchronizer for the asynchronous trig plus one edge-detect stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= trig;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign trig_rise = sync2_q & ~prev_q;
    assign trig_fall = ~sync2_q & prev_q;

    // Saturating increment, and echo length derived from the distance inputs
    always_comb begin
        cnt_inc      = (&cnt_q) ? cnt_q : cnt_q + 22'd1;
        dist_clamped = (dist_cm > MAXD_C) ? MAXD_C : dist_cm;
        len_calc     = 22'(dist_clamped) * CPC_C;
        if (!obj_present || dist_cm == 9'd0) begin
            len_calc = TIMEOUT_C;
        end
    end

    // Next-state and output logic; echo/busy/trig_err are registered from the next values
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        echo_len_d = echo_len_q;
        echo_d     = echo_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig_rise) begin
                    state_d = TRIG_MEAS;
                    cnt_d   = 22'd1;
                end
            end
            TRIG_MEAS: begin
                if (trig_fall) begin
                    cnt_d = 22'd0;
                    if (cnt_q >= MIN_C) begin
                        echo_len_d = len_calc;
                        state_d    = BURST;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            BURST: begin
                // Entered with count 0; this exit point gives the fixed trig-to-echo latency
                if (cnt_q >= DELAY_C) begin
                    state_d = ECHO;
                    echo_d  = 1'b1;
                    cnt_d   = 22'd1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ECHO: begin
                // Count starts at 1 on the first echo-high cycle, so echo stays high echo_len cycles
                if (cnt_q >= echo_len_q) begin
                    state_d = HOLDOFF;
                    echo_d  = 1'b0;
                    cnt_d   = 22'd1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HOLDOFF: begin
                if (cnt_q >= HOLD_C) begin
                    state_d = IDLE;
                    cnt_d   = 22'd0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                echo_d  = 1'b0;
                cnt_d   = 22'd0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 22'd0;
            echo_len_q <= 22'd0;
            echo_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            echo_len_q <= echo_len_d;
            echo_q     <= echo_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign echo     = echo_q;
    assign busy     = busy_q;
    assign trig_err = err_q;

endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
// Directed bench for ultrasonic_echo_emulator using scaled-down timing parameters.
module tb_ultrasonic_echo_emulator;

    localparam int CPC   = 3;
    localparam int MINT  = 8;
    localparam int DLY   = 20;
    localparam int MAXD  = 400;
    localparam int TMO   = 1500;
    localparam int HOLD  = 100;
    localparam int LIMIT = 5000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       trig = 1'b0;
    logic [8:0] dist_cm = 9'd10;
    logic       obj_present = 1'b1;
    logic       echo, busy, trig_err;

    int n_assert = 0;
    int n_fail   = 0;
    int err_seen = 0;

    ultrasonic_echo_emulator #(
        .CLK_FREQ(50000000), .CYCLES_PER_CM(CPC), .MIN_TRIG_CYCLES(MINT),
        .ECHO_DELAY_CYCLES(DLY), .MAX_DIST_CM(MAXD), .TIMEOUT_CYCLES(TMO),
        .HOLDOFF_CYCLES(HOLD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .trig(trig), .dist_cm(dist_cm),
        .obj_present(obj_present), .echo(echo), .busy(busy), .trig_err(trig_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // trig high for exactly n rising edges, driven on falling edges
    task automatic pulse_trig(input int n);
        @(negedge clk);
        trig = 1'b1;
        repeat (n) @(negedge clk);
        trig = 1'b0;
    endtask

    // Accepted trigger followed by full echo/holdoff measurement; glitch adds trig noise
    task automatic run_echo(input string tag, input int exp_len, input bit glitch);
        int lat, w, h;
        bit busy_at_fall;
        err_seen = 0;
        pulse_trig(MINT);
        lat = 0;
        do begin
            @(posedge clk); #1;
            if (trig_err) err_seen++;
            lat++;
            trig = glitch && (lat >= 5 && lat < 14);
        end while (!echo && lat < LIMIT);
        trig = 1'b0;
        check({tag, " latency"}, lat - 1, DLY + 3);
        w = 0;
        do begin
            @(posedge clk); #1;
            if (trig_err) err_seen++;
            w++;
            if (glitch) begin
                trig = (w >= 5 && w < 15) || (w >= 20 && w < 22);
                if (w == 10) dist_cm = 9'd500;
                if (w == 12) obj_present = 1'b0;
            end
        end while (echo && w < LIMIT);
        trig = 1'b0;
        busy_at_fall = busy;
        check({tag, " width"}, w, exp_len);
        check({tag, " busy at echo fall"}, int'(busy_at_fall), 1);
        h = 0;
        do begin
            @(posedge clk); #1;
            if (trig_err) err_seen++;
            if (echo) err_seen += 100;
            h++;
            if (glitch) trig = (h >= 10 && h < 20) || (h >= 40 && h < 43);
        end while (busy && h < LIMIT);
        trig = 1'b0;
        check({tag, " holdoff"}, h, HOLD);
        check({tag, " no trig_err/echo"}, err_seen, 0);
    endtask

    initial begin
        int errs, echos, h;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset echo", int'(echo), 0);
        check("reset busy", int'(busy), 0);
        check("reset trig_err", int'(trig_err), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Nominal: 10 cm -> 30 cycles
        dist_cm = 9'd10; obj_present = 1'b1;
        run_echo("d10", 10 * CPC, 1'b0);

        // Short trigger rejected
        errs = 0; echos = 0;
        pulse_trig(MINT - 1);
        repeat (12) begin
            @(posedge clk); #1;
            if (trig_err) errs++;
            if (echo) echos++;
        end
        check("short trig_err pulses", errs, 1);
        check("short echo", echos, 0);
        check("short busy", int'(busy), 0);

        // Clamp and timeout widths
        dist_cm = 9'd500; run_echo("d500 clamp", MAXD * CPC, 1'b0);
        dist_cm = 9'd400; run_echo("d400", MAXD * CPC, 1'b0);
        dist_cm = 9'd1;   run_echo("d1", CPC, 1'b0);
        dist_cm = 9'd0;   run_echo("d0 timeout", TMO, 1'b0);
        dist_cm = 9'd10; obj_present = 1'b0;
        run_echo("no object", TMO, 1'b0);

        // Trig noise in burst/echo/holdoff, inputs changed mid-echo
        dist_cm = 9'd25; obj_present = 1'b1;
        run_echo("glitch", 25 * CPC, 1'b1);

        // trig held high across end of holdoff is not re-accepted
        dist_cm = 9'd10; obj_present = 1'b1;
        pulse_trig(MINT);
        h = 0;
        do begin @(posedge clk); #1; h++; end while (!echo && h < LIMIT);
        h = 0;
        do begin @(posedge clk); #1; h++; end while (echo && h < LIMIT);
        h = 0;
        do begin
            @(posedge clk); #1; h++;
            if (h >= HOLD - 10) trig = 1'b1;
        end while (busy && h < LIMIT);
        echos = 0; errs = 0;
        repeat (DLY + 40) begin
            @(posedge clk); #1;
            if (echo || busy) echos++;
            if (trig_err) errs++;
        end
        check("held trig no restart", echos, 0);
        check("held trig no trig_err", errs, 0);
        @(negedge clk); trig = 1'b0;
        repeat (4) @(negedge clk);
        run_echo("after held trig", 10 * CPC, 1'b0);

        // Asynchronous reset mid-echo
        dist_cm = 9'd100;
        pulse_trig(MINT);
        h = 0;
        do begin @(posedge clk); #1; h++; end while (!echo && h < LIMIT);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset echo", int'(echo), 0);
        check("async reset busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        dist_cm = 9'd10;
        run_echo("after reset", 10 * CPC, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ultrasonic_echo_emulator.md
Name: ultrasonic_echo_emulator

Overview:
Synthesizable stand-in for an HC-SR04-style ultrasonic ranging sensor: the responder end of the trig/echo interface driven by the parking-sensor controller. Accepts a trigger pulse and returns an echo pulse whose width encodes a distance supplied by switches, a test bench or a scenario generator. Used for on-board loopback testing of the parking-sensor path without a physical sensor, and as the sensor model in system simulation.

Parameters:
CLK_FREQ, 50000000, system clock in Hz (documentation only; all timing is in cycles)
CYCLES_PER_CM, 2915, echo-high cycles per cm of distance
MIN_TRIG_CYCLES, 500, minimum synchronized trig-high length that is accepted (10 us)
ECHO_DELAY_CYCLES, 25000, burst time from accepted trig fall to echo rise (500 us)
MAX_DIST_CM, 400, distance clamp
TIMEOUT_CYCLES, 1900000, echo width when no object is present (38 ms)
HOLDOFF_CYCLES, 500000, dead time after echo fall during which trig is ignored (10 ms)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
trig  in  1  trigger from controller, asynchronous to clk
dist_cm  in  9  simulated distance in cm, sampled at trig acceptance
obj_present  in  1  1 = object in range; 0 = no echo return (timeout width)
echo  out  1  echo pulse to controller, registered
busy  out  1  high in every state except IDLE
trig_err  out  1  one-cycle pulse when a trig pulse shorter than MIN_TRIG_CYCLES is rejected

Behaviour:
- Reset (rst_n=0, asynchronous): echo=0, busy=0, trig_err=0, state=IDLE, all counters 0, synchronizer flops 0, latched echo length 0.
- trig passes through a 2-FF synchronizer; one further flop gives edge detection. Rise = sync 1 and prev 0; fall = sync 0 and prev 1.
- Counter: 22 bits, saturating at all-ones. Echo length: 22 bits. 400*2915=1166000 and 1900000 both fit.
- States:
  - IDLE: on synced rise, go to TRIG_MEAS with counter=1. A level-high trig without a rise is ignored; a trig still high after HOLDOFF must go low before it can be re-accepted.
  - TRIG_MEAS: counter increments each cycle while synced trig is high. On fall:
    - if counter >= MIN_TRIG_CYCLES, latch echo_len and go to BURST with counter=0;
    - otherwise pulse trig_err for one cycle and return to IDLE.
  - Echo length latched on acceptance:
    - obj_present=0 or dist_cm=0: echo_len = TIMEOUT_CYCLES;
    - otherwise echo_len = min(dist_cm, MAX_DIST_CM) * CYCLES_PER_CM.
  - BURST: count ECHO_DELAY_CYCLES cycles, then go to ECHO and drive echo=1.
  - ECHO: echo stays high for exactly echo_len clocks, then echo=0 and go to HOLDOFF.
  - HOLDOFF: count HOLDOFF_CYCLES cycles, then go to IDLE. trig edges are ignored and produce no trig_err.
- Latency: echo rises exactly ECHO_DELAY_CYCLES+3 clocks after the first clk edge at which raw trig is sampled low (2 sync stages + 1 edge detect). The echo-high width is exactly echo_len cycles, with no ±1 tolerance, because the controller measures width per cycle.
- dist_cm and obj_present changes after acceptance have no effect until the next accepted trig.
- trig activity during BURST or ECHO is ignored; the echo is never truncated or restarted.
- Reset asserted mid-echo: echo falls asynchronously, busy=0, state=IDLE. After release, the first accepted trig behaves normally.
- busy is registered and follows the state with no extra cycle of lag relative to the state register.

Test Plan:
- Reset, dist_cm=10, obj_present=1, trig high for 500 cycles -> echo rises 25003 cycles after trig low sample, high exactly 29150 cycles; busy high through HOLDOFF, low 500000 cycles after echo fall.
- trig high for 499 cycles -> one trig_err pulse, echo stays 0, busy returns to 0 right after the rejection.
- dist_cm=500 -> echo width 1166000 cycles (clamped to 400 cm); dist_cm=0 or obj_present=0 -> echo width 1900000 cycles.
- Extra trig pulses during BURST, ECHO and HOLDOFF; dist_cm changes mid-echo -> echo width unchanged, no trig_err, no second echo; trig held high across the end of HOLDOFF -> no echo until trig goes low and high again.
- rst_n pulsed low for 3 cycles mid-echo -> echo=0 immediately (asynchronous), next valid trig yields a correct full-length echo.
- Loopback with the parking-sensor controller (trig generated every 4000001 cycles), dist_cm=15 -> the controller's measured width is 43725 cycles; in stop mode its signal output is 1; with dist_cm=25 its signal output is 0.
